cmd_sequencer: RTL and testbench
================================

# cmd_sequencer

Command sequencer between the host-side command inputs (ValidCmd/RW/ConfigDiv/InputKey/Sel/Addr/Din) and the shared memory port, the ALU operand registers and the clock-divider configuration. It accepts one command at a time and decodes it into one of three actions:
- a memory write;
- a memory read, with optional load of ALU operand inA/inB;
- a protected divider-configuration write.

It runs the memory req/ack handshake with an optional timeout and reports exactly one completion or error pulse per accepted command.

## Interface
- INBITS, 8, ALU operand width (OpA/OpB)
- WIDTH, 8, address width
- TIMEOUT, 15, max cycles MemReq may stay high without MemAck (1..255)
- Clk  in  1  clock, all logic on posedge
- Reset  in  1  asynchronous, active-low reset
- ValidCmd  in  1  command present
- RW  in  1  1 = memory write, 0 = memory read
- ConfigDiv  in  1  1 = divider config command (overrides RW)
- InputKey  in  1  config unlock; must be 1 at acceptance of a config command
- Sel  in  4  read destination: 0 = Dout only, 1 = also OpA, 2 = also OpB, 3..15 reserved
- Addr  in  WIDTH  memory address
- Din  in  32  write data / divider value (Din[15:0])
- Busy  out  1  memory transaction in flight; commands ignored while high
- MemReq  out  1  memory request
- MemWe  out  1  write enable, valid with MemReq
- MemAddr  out  WIDTH  latched Addr
- MemWdata  out  32  latched Din
- MemAck  in  1  memory acknowledge, sampled only while MemReq=1
- MemRdata  in  32  read data, valid with MemAck
- Dout  out  32  last read data
- DoutValid  out  1  one-cycle pulse, Dout updated
- OpA, OpB  out  INBITS  ALU operands (drive inA/inB)
- DivCfg  out  16  clock-divider ratio
- Done  out  1  one-cycle pulse, command completed
- CmdErr  out  1  one-cycle pulse, command rejected or aborted

## Operation
- **Reset values.** Reset low forces these values immediately, including mid-transaction, and drops MemReq at once:
  - Busy, MemReq, MemWe, DoutValid, Done, CmdErr = 0
  - MemAddr, MemWdata, Dout, OpA, OpB = 0
  - DivCfg = 16'd1
  - FSM = IDLE
- **Acceptance.** A command is accepted at a posedge where ValidCmd=1 and Busy=0. ValidCmd while Busy=1 is ignored; there is no queuing.
- **Decode priority.** ConfigDiv, then RW, then read.
- **Config command.**
  - If InputKey=1 and Din[15:0]≠0: DivCfg←Din[15:0] and Done pulses.
  - Otherwise: CmdErr pulses and DivCfg is unchanged.
  - No memory access; Busy stays 0.
- **Read with reserved Sel (3..15).** CmdErr pulses, no memory access, Busy stays 0.
- **Memory command.** Addr, Din, RW and Sel are latched; FSM goes IDLE→MEM_WAIT with Busy=1, MemReq=1.
- **MemAck=1 in MEM_WAIT.** FSM goes to IDLE.
  - Write: Done pulses.
  - Read: Dout←MemRdata, DoutValid and Done pulse. Sel=1 sets OpA←MemRdata[INBITS-1:0]; Sel=2 sets OpB←MemRdata[INBITS-1:0].
- **Timeout (macro enabled).** The wait counter reaches TIMEOUT with no ack → FSM goes to IDLE, MemReq drops, CmdErr pulses. Dout, OpA and OpB are unchanged.
- **States.** IDLE and MEM_WAIT only. Done/CmdErr/DoutValid are registered pulses generated on the exiting edge.
- **Pulse exclusivity.** Exactly one of Done or CmdErr pulses per accepted command; never both in one cycle.

## Timing
- **Accept edge E.**
  - Config or reject: Done/CmdErr and DivCfg valid in cycle E+1.
  - Memory command: Busy=MemReq=1 from cycle E+1.
- **Request hold.** MemReq, MemWe, MemAddr and MemWdata hold stable until MemAck is sampled.
- **Ack at edge K.**
  - In cycle K+1: MemReq=0, Busy=0, Done (and DoutValid/Dout/OpX) valid.
  - A new command can be accepted at edge K+1.
  - Minimum memory-command latency: accept to Done = 2 cycles (ack in cycle E+1).
- **Wait counter.** Clears on accept and increments each MEM_WAIT cycle with MemAck=0. The abort takes effect in the cycle after TIMEOUT such cycles.
- **Ack/timeout collision.** If MemAck=1 on the edge where the counter reaches TIMEOUT, the ack wins and the result is Done, not CmdErr.
- **Back-to-back configs.** One per cycle is allowed, since Busy stays 0.

## Configuration
- **SEQ_TIMEOUT_EN defined:** the wait counter and abort path are compiled in, as specified above.
- **SEQ_TIMEOUT_EN undefined:** no counter; MEM_WAIT waits indefinitely for MemAck; CmdErr arises only from config or Sel rejections; the TIMEOUT parameter is unused.

## Structure
- **Package cmd_seq_pkg:**
  - FSM state enum (IDLE, MEM_WAIT)
  - Sel encodings (SEL_NONE=0, SEL_OPA=1, SEL_OPB=2)
  - DIV_RESET=16'd1
  - command-kind enum (CFG, WR, RD)
- **Sub-module cmd_seq_timeout:** TIMEOUT-bounded wait counter with clear/enable inputs and an expired output; instantiated only under SEQ_TIMEOUT_EN.

## Test plan
- Reset release → DivCfg=1, all pulses/requests 0. Assert Reset low during MEM_WAIT → MemReq=0 immediately and no Done.
- Write Addr=8'h10, Din=32'hDEADBEEF, MemAck after 3 cycles → MemReq held 3 cycles with MemWe=1 and MemAddr=8'h10, Done one cycle after ack, Busy=0.
- Read Sel=1 then Sel=2, MemRdata=32'h0000_00A5 then 32'h0000_003C:
  - first read → Dout=32'h0000_00A5, OpA=8'hA5, DoutValid and Done;
  - second read → Dout=32'h0000_003C, OpB=8'h3C, DoutValid and Done.
- Config Din=16'd4: InputKey=1 → DivCfg=4 and Done. InputKey=0 → CmdErr, DivCfg stays 4. Din=0 with key → CmdErr.
- ValidCmd held while Busy → only the first command executes. Read with Sel=7 → CmdErr, no MemReq.
- SEQ_TIMEOUT_EN, TIMEOUT=15:
  - no ack → CmdErr in the cycle after 15 wait cycles, MemReq dropped;
  - ack on exactly the 15th wait cycle → Done, no CmdErr.

Source files
------------

// File: rtl/cmd_seq_pkg.sv
// cmd_seq_pkg: shared types and constants for the command sequencer.
package cmd_seq_pkg;
    typedef enum logic [0:0] {IDLE = 1'b0, MEM_WAIT = 1'b1} state_e;
    typedef enum logic [1:0] {CFG = 2'd0, WR = 2'd1, RD = 2'd2} kind_e;
    localparam logic [3:0] SEL_NONE = 4'd0;
    localparam logic [3:0] SEL_OPA = 4'd1;
    localparam logic [3:0] SEL_OPB = 4'd2;
    localparam logic [15:0] DIV_RESET = 16'd1;
    function automatic kind_e cmd_kind(input logic cfg, input logic rw);
        return cfg ? CFG : (rw ? WR : RD);
    endfunction
endpackage

// File: rtl/cmd_seq_timeout.sv
// cmd_seq_timeout: counts memory wait cycles without ack; expired_o flags the cycle that reaches TIMEOUT.
module cmd_seq_timeout #(
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [7:0] cnt_q;
    assign expired_o = en_i && cnt_q == 8'(TIMEOUT - 1);
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            cnt_q <= '0;
        else if (clr_i)
            cnt_q <= '0;
        else if (en_i)
            cnt_q <= cnt_q + 8'd1;
    end
endmodule

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: decodes host commands into memory read/write or protected divider config.
// Define SEQ_TIMEOUT_EN to abort memory transactions that see no ack within TIMEOUT cycles.
module cmd_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int INBITS = 8,
    parameter int WIDTH = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_cmd_i,
    input  logic              rw_i,
    input  logic              config_div_i,
    input  logic              input_key_i,
    input  logic [3:0]        sel_i,
    input  logic [WIDTH-1:0]  addr_i,
    input  logic [31:0]       din_i,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [WIDTH-1:0]  mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i,
    output logic [31:0]       dout_o,
    output logic              dout_valid_o,
    output logic [INBITS-1:0] op_a_o,
    output logic [INBITS-1:0] op_b_o,
    output logic [15:0]       div_cfg_o,
    output logic              done_o,
    output logic              cmd_err_o
);
    state_e state_q, state_d;
    logic we_q, we_d, dv_q, dv_d, done_q, done_d, err_q, err_d;
    logic [3:0] sel_q, sel_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d, dout_q, dout_d;
    logic [INBITS-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [15:0] div_q, div_d;
    logic accept, tmo_expired;
    kind_e kind;
    assign accept = valid_cmd_i && state_q == IDLE;
    assign kind = cmd_kind(config_div_i, rw_i);
`ifdef SEQ_TIMEOUT_EN
    cmd_seq_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (accept),
        .en_i      (state_q == MEM_WAIT && !mem_ack_i),
        .expired_o (tmo_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^8'(TIMEOUT);
    assign tmo_expired = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        we_d = we_q;
        sel_d = sel_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        dout_d = dout_q;
        opa_d = opa_q;
        opb_d = opb_q;
        div_d = div_q;
        dv_d = 1'b0;
        done_d = 1'b0;
        err_d = 1'b0;
        if (accept) begin
            if (kind == CFG) begin
                if (input_key_i && din_i[15:0] != 16'd0) begin
                    div_d = din_i[15:0];
                    done_d = 1'b1;
                end else
                    err_d = 1'b1;
            end else if (kind == RD && sel_i > SEL_OPB) begin
                err_d = 1'b1;
            end else begin
                state_d = MEM_WAIT;
                we_d = kind == WR;
                sel_d = sel_i;
                addr_d = addr_i;
                wdata_d = din_i;
            end
        end else if (state_q == MEM_WAIT) begin
            // an ack on the timeout edge still completes the command
            if (mem_ack_i) begin
                state_d = IDLE;
                done_d = 1'b1;
                if (!we_q) begin
                    dout_d = mem_rdata_i;
                    dv_d = 1'b1;
                    opa_d = sel_q == SEL_OPA ? mem_rdata_i[INBITS-1:0] : opa_q;
                    opb_d = sel_q == SEL_OPB ? mem_rdata_i[INBITS-1:0] : opb_q;
                end
            end else if (tmo_expired) begin
                state_d = IDLE;
                err_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            we_q <= 1'b0;
            sel_q <= SEL_NONE;
            addr_q <= '0;
            wdata_q <= '0;
            dout_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            div_q <= DIV_RESET;
            dv_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q <= we_d;
            sel_q <= sel_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            dout_q <= dout_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            div_q <= div_d;
            dv_q <= dv_d;
            done_q <= done_d;
            err_q <= err_d;
        end
    end
    assign busy_o = state_q == MEM_WAIT;
    assign mem_req_o = state_q == MEM_WAIT;
    assign mem_we_o = we_q;
    assign mem_addr_o = addr_q;
    assign mem_wdata_o = wdata_q;
    assign dout_o = dout_q;
    assign dout_valid_o = dv_q;
    assign op_a_o = opa_q;
    assign op_b_o = opb_q;
    assign div_cfg_o = div_q;
    assign done_o = done_q;
    assign cmd_err_o = err_q;
endmodule

// File: tb/tb_cmd_sequencer.sv
// tb_cmd_sequencer: directed and random commands checked every cycle against a transaction-level model.
module tb_cmd_sequencer;
    localparam int TIMEOUT = 15;
    logic clk = 1'b0, rst_n = 1'b1;
    logic valid_cmd = 1'b0, rw = 1'b0, config_div = 1'b0, input_key = 1'b0, mem_ack = 1'b0;
    logic [3:0] sel = '0;
    logic [7:0] addr = '0;
    logic [31:0] din = '0, mem_rdata = '0;
    logic busy_o, mem_req_o, mem_we_o, dout_valid_o, done_o, cmd_err_o;
    logic [7:0] mem_addr_o, op_a_o, op_b_o;
    logic [31:0] mem_wdata_o, dout_o;
    logic [15:0] div_cfg_o;

    always #5 clk = ~clk;

    cmd_sequencer #(.INBITS(8), .WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .valid_cmd_i(valid_cmd), .rw_i(rw),
        .config_div_i(config_div), .input_key_i(input_key), .sel_i(sel),
        .addr_i(addr), .din_i(din), .busy_o(busy_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata), .dout_o(dout_o),
        .dout_valid_o(dout_valid_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
        .div_cfg_o(div_cfg_o), .done_o(done_o), .cmd_err_o(cmd_err_o)
    );

    int n_checks = 0, n_fail = 0;
    int n_acc = 0, n_pulse = 0;
    bit chk_en = 1'b0;

    // Model: one outstanding memory command plus the architectural registers it can update.
    logic e_busy = 0, e_we = 0, e_dv = 0, e_done = 0, e_err = 0;
    logic [7:0] e_addr = 0, e_opa = 0, e_opb = 0;
    logic [31:0] e_wdata = 0, e_dout = 0;
    logic [15:0] e_div = 16'd1;
    logic [3:0] m_sel = 0;
    int m_wait = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        if (e_busy) n_acc--;
        e_busy = 0; e_we = 0; e_dv = 0; e_done = 0; e_err = 0;
        e_addr = 0; e_wdata = 0; e_dout = 0; e_opa = 0; e_opb = 0;
        e_div = 16'd1;
    endtask

    task automatic model_step();
        e_done = 0; e_err = 0; e_dv = 0;
        if (!e_busy) begin
            if (valid_cmd) begin
                n_acc++;
                if (config_div) begin
                    if (input_key && din[15:0] != 0) begin
                        e_div = din[15:0];
                        e_done = 1;
                    end else
                        e_err = 1;
                end else if (!rw && sel > 2)
                    e_err = 1;
                else begin
                    e_busy = 1; e_we = rw; e_addr = addr; e_wdata = din; m_sel = sel; m_wait = 0;
                end
            end
        end else if (mem_ack) begin
            e_busy = 0;
            e_done = 1;
            if (!e_we) begin
                e_dout = mem_rdata;
                e_dv = 1;
                if (m_sel == 1) e_opa = mem_rdata[7:0];
                if (m_sel == 2) e_opb = mem_rdata[7:0];
            end
        end else begin
            m_wait++;
`ifdef SEQ_TIMEOUT_EN
            if (m_wait == TIMEOUT) begin
                e_busy = 0;
                e_err = 1;
            end
`endif
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy_o), 32'(e_busy));
            check("mem_req", 32'(mem_req_o), 32'(e_busy));
            if (e_busy) check("mem_we", 32'(mem_we_o), 32'(e_we));
            check("mem_addr", 32'(mem_addr_o), 32'(e_addr));
            check("mem_wdata", mem_wdata_o, e_wdata);
            check("dout", dout_o, e_dout);
            check("dout_valid", 32'(dout_valid_o), 32'(e_dv));
            check("op_a", 32'(op_a_o), 32'(e_opa));
            check("op_b", 32'(op_b_o), 32'(e_opb));
            check("div_cfg", 32'(div_cfg_o), 32'(e_div));
            check("done", 32'(done_o), 32'(e_done));
            check("cmd_err", 32'(cmd_err_o), 32'(e_err));
            n_pulse += int'(done_o) + int'(cmd_err_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic cmd(input logic v, input logic cfg, input logic w, input logic key,
                       input logic [3:0] s, input logic [7:0] a, input logic [31:0] d);
        valid_cmd = v; config_div = cfg; rw = w; input_key = key; sel = s; addr = a; din = d;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        model_reset();
        chk_en = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        check("rst_div", 32'(div_cfg_o), 32'h1);
        check("rst_req", 32'(mem_req_o), 32'h0);
        check("rst_done", 32'(done_o), 32'h0);
        @(negedge clk);

        // write with ack in the third request cycle
        cmd(1, 0, 1, 0, 0, 8'h10, 32'hDEADBEEF);
        tick();
        cmd(0, 0, 0, 0, 0, 8'h00, 32'h0);
        check("wr_req", 32'(mem_req_o), 32'h1);
        check("wr_we", 32'(mem_we_o), 32'h1);
        check("wr_addr", 32'(mem_addr_o), 32'h10);
        tick();
        tick();
        mem_ack = 1;
        tick();
        mem_ack = 0;
        check("wr_done", 32'(done_o), 32'h1);
        check("wr_busy", 32'(busy_o), 32'h0);

        // reads into OpA then OpB, ack right away
        cmd(1, 0, 0, 0, 4'd1, 8'h20, 32'h0);
        tick();
        cmd(0, 0, 0, 0, 0, 8'h00, 32'h0);
        mem_ack = 1; mem_rdata = 32'h0000_00A5;
        tick();
        mem_ack = 0;
        check("rd1_dout", dout_o, 32'h0000_00A5);
        check("rd1_opa", 32'(op_a_o), 32'hA5);
        check("rd1_dv", 32'(dout_valid_o), 32'h1);
        check("rd1_done", 32'(done_o), 32'h1);
        cmd(1, 0, 0, 0, 4'd2, 8'h21, 32'h0);
        tick();
        cmd(0, 0, 0, 0, 0, 8'h00, 32'h0);
        mem_ack = 1; mem_rdata = 32'h0000_003C;
        tick();
        mem_ack = 0;
        check("rd2_dout", dout_o, 32'h0000_003C);
        check("rd2_opb", 32'(op_b_o), 32'h3C);
        check("rd2_opa", 32'(op_a_o), 32'hA5);
        check("rd2_done", 32'(done_o), 32'h1);

        // back-to-back config commands
        cmd(1, 1, 0, 1, 0, 8'h00, 32'd4);
        tick();
        check("cfg_div", 32'(div_cfg_o), 32'd4);
        check("cfg_done", 32'(done_o), 32'h1);
        cmd(1, 1, 0, 0, 0, 8'h00, 32'd9);
        tick();
        check("cfg_nokey_err", 32'(cmd_err_o), 32'h1);
        check("cfg_nokey_div", 32'(div_cfg_o), 32'd4);
        cmd(1, 1, 1, 1, 0, 8'h00, 32'hFFFF_0000);
        tick();
        check("cfg_zero_err", 32'(cmd_err_o), 32'h1);
        check("cfg_zero_div", 32'(div_cfg_o), 32'd4);

        // ValidCmd held while busy
        cmd(1, 0, 1, 0, 0, 8'h30, 32'h1);
        tick();
        cmd(1, 0, 1, 0, 0, 8'h31, 32'h2);
        tick();
        tick();
        mem_ack = 1;
        tick();
        cmd(0, 0, 0, 0, 0, 8'h00, 32'h0);
        mem_ack = 0;
        check("hold_done", 32'(done_o), 32'h1);
        check("hold_addr", 32'(mem_addr_o), 32'h30);
        tick();
        check("hold_idle", 32'(busy_o), 32'h0);

        // reserved Sel
        cmd(1, 0, 0, 0, 4'd7, 8'h40, 32'h0);
        tick();
        cmd(0, 0, 0, 0, 0, 8'h00, 32'h0);
        check("sel7_err", 32'(cmd_err_o), 32'h1);
        check("sel7_req", 32'(mem_req_o), 32'h0);

`ifdef SEQ_TIMEOUT_EN
        cmd(1, 0, 0, 0, 4'd1, 8'h50, 32'h0);
        tick();
        cmd(0, 0, 0, 0, 0, 8'h00, 32'h0);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check("tmo_still_req", 32'(mem_req_o), 32'h1);
        tick();
        check("tmo_err", 32'(cmd_err_o), 32'h1);
        check("tmo_req", 32'(mem_req_o), 32'h0);
        cmd(1, 0, 0, 0, 4'd2, 8'h51, 32'h0);
        tick();
        cmd(0, 0, 0, 0, 0, 8'h00, 32'h0);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        mem_ack = 1; mem_rdata = 32'h0000_0077;
        tick();
        mem_ack = 0;
        check("coll_done", 32'(done_o), 32'h1);
        check("coll_err", 32'(cmd_err_o), 32'h0);
        check("coll_opb", 32'(op_b_o), 32'h77);
`else
        cmd(1, 0, 1, 0, 0, 8'h50, 32'h5);
        tick();
        cmd(0, 0, 0, 0, 0, 8'h00, 32'h0);
        for (int i = 0; i < 2 * TIMEOUT; i++) tick();
        check("nto_req", 32'(mem_req_o), 32'h1);
        mem_ack = 1;
        tick();
        mem_ack = 0;
        check("nto_done", 32'(done_o), 32'h1);
`endif

        // asynchronous reset in the middle of a read
        cmd(1, 0, 0, 0, 4'd1, 8'h60, 32'h0);
        tick();
        cmd(0, 0, 0, 0, 0, 8'h00, 32'h0);
        tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_req", 32'(mem_req_o), 32'h0);
        check("arst_busy", 32'(busy_o), 32'h0);
        check("arst_div", 32'(div_cfg_o), 32'h1);
        check("arst_opa", 32'(op_a_o), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        mem_ack = 1;
        tick();
        mem_ack = 0;
        check("arst_nodone", 32'(done_o), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            valid_cmd = $urandom_range(0, 2) == 0;
            config_div = $urandom_range(0, 4) == 0;
            input_key = $urandom_range(0, 3) != 0;
            rw = 1'($urandom_range(0, 1));
            sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
            addr = 8'($urandom);
            din = $urandom;
            if ($urandom_range(0, 5) == 0) din[15:0] = 16'h0;
            mem_ack = $urandom_range(0, 7) == 0;
            mem_rdata = $urandom;
            tick();
        end
        valid_cmd = 0;
        mem_ack = 1;
        tick();
        tick();
        #1;
        check("pulse_per_cmd", 32'(n_pulse), 32'(n_acc));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
